// File: rtl/sif_wa_responder.sv
// XA-side command responder: decodes write/read/illegal strobes, buffers written
// words in a small FIFO and streams them out on the WA valid/ready port.
module sif_wa_responder #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   xa_wr_s,
  input  logic                   xa_rd_s,
  input  logic [DATA_W-1:0]      xa_data_in,
  output logic [DATA_W-1:0]      xa_data_out,
  output logic                   xa_rd_valid,
  output logic                   xa_illegal,
  output logic                   wa_valid,
  output logic [DATA_W-1:0]      wa_data,
  input  logic                   wa_ready,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] LEVEL_ONE    = LW'(1);
  localparam logic [LW-1:0] LEVEL_ALMOST = LW'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HOLD  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t            state;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [DATA_W-1:0] last_wr;
  logic [DATA_W-1:0] mem [DEPTH];

  logic is_write;
  logic is_read;
  logic is_illegal;
  logic pop;
  logic push;
  logic drop;

  always_comb begin
    is_write   = 1'b0;
    is_read    = 1'b0;
    is_illegal = 1'b0;
    case ({xa_wr_s, xa_rd_s})
      2'b10:   is_write   = 1'b1;
      2'b01:   is_read    = 1'b1;
      2'b11:   is_illegal = 1'b1;
      default: ;
    endcase
  end

  // A pop frees a slot in the same cycle, so a write into a full FIFO still lands.
  assign pop  = wa_valid & wa_ready;
  assign push = is_write & ((state != ST_FULL) | pop);
  assign drop = is_write & (state == ST_FULL) & ~pop;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= xa_data_in;
    end
  end

  // wa_valid is a register, so gating here also forces wa_data to 0 during reset.
  assign wa_data = wa_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_EMPTY;
      wa_valid <= 1'b0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (push) begin
            state    <= ST_HOLD;
            wa_valid <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (pop && !push && level == LEVEL_ONE) begin
            state    <= ST_EMPTY;
            wa_valid <= 1'b0;
          end else if (push && !pop && level == LEVEL_ALMOST) begin
            state <= ST_FULL;
          end
        end
        ST_FULL: begin
          if (pop && !push) begin
            state <= ST_HOLD;
          end
        end
        default: begin
          state    <= ST_EMPTY;
          wa_valid <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_wr     <= '0;
      xa_data_out <= '0;
      xa_rd_valid <= 1'b0;
      xa_illegal  <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      xa_rd_valid <= is_read;
      xa_illegal  <= is_illegal;
      if (is_read) begin
        xa_data_out <= last_wr;
      end
      if (push) begin
        last_wr <= xa_data_in;
      end
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sif_wa_responder.sv
// Self-checking bench for sif_wa_responder against a queue-based reference model.
module tb_sif_wa_responder;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 4;
  localparam int LW     = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              xa_wr_s = 1'b0;
  logic              xa_rd_s = 1'b0;
  logic [DATA_W-1:0] xa_data_in = '0;
  logic              wa_ready = 1'b0;
  logic [DATA_W-1:0] xa_data_out;
  logic              xa_rd_valid;
  logic              xa_illegal;
  logic              wa_valid;
  logic [DATA_W-1:0] wa_data;
  logic              overflow;
  logic [LW-1:0]     level;

  always #5 clk = ~clk;

  sif_wa_responder #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .xa_wr_s(xa_wr_s), .xa_rd_s(xa_rd_s),
    .xa_data_in(xa_data_in), .xa_data_out(xa_data_out), .xa_rd_valid(xa_rd_valid),
    .xa_illegal(xa_illegal), .wa_valid(wa_valid), .wa_data(wa_data),
    .wa_ready(wa_ready), .overflow(overflow), .level(level)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: FIFO contents, last written word, sticky overflow, pulses.
  logic [DATA_W-1:0] m_q[$];
  logic [DATA_W-1:0] m_last;
  logic [DATA_W-1:0] m_rdata;
  logic              m_ovf;
  logic              m_rdv;
  logic              m_ill;
  logic [DATA_W-1:0] d_popped[$];

  function automatic void m_reset();
    m_q.delete();
    m_last  = '0;
    m_rdata = '0;
    m_ovf   = 1'b0;
    m_rdv   = 1'b0;
    m_ill   = 1'b0;
  endfunction

  function automatic logic [DATA_W-1:0] m_head();
    return (m_q.size() > 0) ? m_q[0] : '0;
  endfunction

  task automatic step(input logic wr, input logic rd, input logic [DATA_W-1:0] d,
                      input logic rdy);
    logic pop;
    xa_wr_s    = wr;
    xa_rd_s    = rd;
    xa_data_in = d;
    wa_ready   = rdy;
    if (wa_valid && rdy) d_popped.push_back(wa_data);
    @(posedge clk);
    pop   = (m_q.size() > 0) && rdy;
    m_rdv = rd && !wr;
    m_ill = rd && wr;
    if (rd && !wr) m_rdata = m_last;
    if (pop) void'(m_q.pop_front());
    if (wr && !rd) begin
      if (m_q.size() < DEPTH) begin
        m_q.push_back(d);
        m_last = d;
      end else begin
        m_ovf = 1'b1;
      end
    end
    #1;
    xa_wr_s = 1'b0;
    xa_rd_s = 1'b0;
    $display("step wr=%0b rd=%0b din=%h rdy=%0b -> level=%0d wa_valid=%0b wa_data=%h",
             wr, rd, d, rdy, level, wa_valid, wa_data);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    m_reset();
    d_popped.delete();
  endtask

  task automatic test_reset();
    logic [2*DATA_W+LW+3:0] outs;
    logic [DATA_W-1:0] w;
    #1 rst_n = 1'b0;
    #2;
    outs = {xa_data_out, xa_rd_valid, xa_illegal, wa_valid, wa_data, overflow, level};
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL reset_initial: outputs got %h expected 0", outs);
    end
    @(negedge clk);
    rst_n = 1'b1;
    m_reset();
    for (int i = 0; i < 3; i++) begin
      w = DATA_W'($urandom_range(1, 16'hFFFF));
      step(1'b1, 1'b0, w, 1'b0);
    end
    step(1'b0, 1'b1, '0, 1'b0);
    checks++;
    if (level !== LW'(3) || xa_rd_valid !== 1'b1 || xa_data_out !== m_rdata) begin
      errors++;
      $display("FAIL reset_preload: level=%0d rd_valid=%0b data=%h expected 3 1 %h",
               level, xa_rd_valid, xa_data_out, m_rdata);
    end
    #2 rst_n = 1'b0;
    #1;
    outs = {xa_data_out, xa_rd_valid, xa_illegal, wa_valid, wa_data, overflow, level};
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL reset_async: outputs got %h expected 0", outs);
    end
    @(negedge clk);
    rst_n = 1'b1;
    m_reset();
    step(1'b0, 1'b0, '0, 1'b0);
    checks++;
    if (level !== '0 || wa_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: level=%0d wa_valid=%0b expected 0 0", level, wa_valid);
    end
  endtask

  task automatic test_write_drain();
    logic [DATA_W-1:0] words [3];
    words[0] = 16'h1234;
    words[1] = 16'hABCD;
    words[2] = 16'h0001;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, words[i], 1'b0);
    checks++;
    if (level !== LW'(3) || wa_data !== 16'h1234) begin
      errors++;
      $display("FAIL write_fill: level=%0d wa_data=%h expected 3 1234", level, wa_data);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (wa_valid !== 1'b1 || wa_data !== words[i]) begin
        errors++;
        $display("FAIL drain_word%0d: valid=%0b data=%h expected 1 %h", i, wa_valid, wa_data, words[i]);
      end
      step(1'b0, 1'b0, '0, 1'b1);
    end
    checks++;
    if (wa_valid !== 1'b0 || wa_data !== '0 || level !== '0) begin
      errors++;
      $display("FAIL drain_empty: valid=%0b data=%h level=%0d expected 0 0 0", wa_valid, wa_data, level);
    end
  endtask

  task automatic test_overflow();
    logic [DATA_W-1:0] w;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, DATA_W'(16'h0010 + i), 1'b0);
    checks++;
    if (level !== LW'(DEPTH) || overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_set: level=%0d overflow=%0b expected 4 1", level, overflow);
    end
    for (int i = 0; i < 4; i++) begin
      w = DATA_W'(16'h0010 + i);
      checks++;
      if (wa_valid !== 1'b1 || wa_data !== w) begin
        errors++;
        $display("FAIL overflow_drain%0d: valid=%0b data=%h expected 1 %h", i, wa_valid, wa_data, w);
      end
      step(1'b0, 1'b0, '0, 1'b1);
    end
    checks++;
    if (wa_valid !== 1'b0 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_after: valid=%0b overflow=%0b expected 0 1", wa_valid, overflow);
    end
    step(1'b0, 1'b1, '0, 1'b0);
    checks++;
    if (xa_rd_valid !== 1'b1 || xa_data_out !== 16'h0013) begin
      errors++;
      $display("FAIL overflow_read: rd_valid=%0b data=%h expected 1 0013", xa_rd_valid, xa_data_out);
    end
    step(1'b0, 1'b0, '0, 1'b0);
    checks++;
    if (xa_rd_valid !== 1'b0 || xa_data_out !== 16'h0013) begin
      errors++;
      $display("FAIL read_hold: rd_valid=%0b data=%h expected 0 0013", xa_rd_valid, xa_data_out);
    end
  endtask

  task automatic test_full_pushpop();
    logic [DATA_W-1:0] expd [5];
    int n;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      expd[i] = DATA_W'(16'h00A0 + i);
      step(1'b1, 1'b0, expd[i], 1'b0);
    end
    expd[4] = 16'h00FF;
    step(1'b1, 1'b0, 16'h00FF, 1'b1);
    checks++;
    if (level !== LW'(DEPTH) || overflow !== 1'b0 || wa_valid !== 1'b1 || wa_data !== 16'h00A1) begin
      errors++;
      $display("FAIL full_pushpop: level=%0d ovf=%0b valid=%0b data=%h expected 4 0 1 00a1",
               level, overflow, wa_valid, wa_data);
    end
    step(1'b0, 1'b0, '0, 1'b0);
    checks++;
    if (level !== LW'(DEPTH) || wa_valid !== 1'b1) begin
      errors++;
      $display("FAIL full_hold: level=%0d valid=%0b expected 4 1", level, wa_valid);
    end
    n = 0;
    while (wa_valid === 1'b1 && n < 10) begin
      step(1'b0, 1'b0, '0, 1'b1);
      n++;
    end
    checks++;
    if (d_popped.size() != 5 || wa_valid !== 1'b0) begin
      errors++;
      $display("FAIL full_drain_count: popped=%0d valid=%0b expected 5 0", d_popped.size(), wa_valid);
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (d_popped[i] !== expd[i]) begin
          errors++;
          $display("FAIL full_drain%0d: got %h expected %h", i, d_popped[i], expd[i]);
        end
      end
    end
  endtask

  task automatic test_read_illegal();
    step(1'b1, 1'b0, 16'hBEEF, 1'b0);
    step(1'b0, 1'b1, '0, 1'b0);
    checks++;
    if (xa_rd_valid !== 1'b1 || xa_data_out !== 16'hBEEF || level !== LW'(1)) begin
      errors++;
      $display("FAIL read_beef: rd_valid=%0b data=%h level=%0d expected 1 beef 1",
               xa_rd_valid, xa_data_out, level);
    end
    step(1'b1, 1'b1, 16'h5555, 1'b0);
    checks++;
    if (xa_illegal !== 1'b1 || xa_rd_valid !== 1'b0 || level !== LW'(1)) begin
      errors++;
      $display("FAIL illegal_pulse: illegal=%0b rd_valid=%0b level=%0d expected 1 0 1",
               xa_illegal, xa_rd_valid, level);
    end
    step(1'b0, 1'b0, '0, 1'b0);
    checks++;
    if (xa_illegal !== 1'b0 || wa_data !== 16'hBEEF) begin
      errors++;
      $display("FAIL illegal_end: illegal=%0b wa_data=%h expected 0 beef", xa_illegal, wa_data);
    end
    step(1'b0, 1'b1, '0, 1'b0);
    checks++;
    if (xa_rd_valid !== 1'b1 || xa_data_out !== 16'hBEEF) begin
      errors++;
      $display("FAIL read_after_illegal: rd_valid=%0b data=%h expected 1 beef", xa_rd_valid, xa_data_out);
    end
  endtask

  task automatic test_back_to_back();
    step(1'b1, 1'b0, 16'h7777, 1'b1);
    step(1'b0, 1'b1, '0, 1'b1);
    checks++;
    if (xa_rd_valid !== 1'b1 || xa_data_out !== 16'h7777 || wa_valid !== 1'b0) begin
      errors++;
      $display("FAIL write_then_read: rd_valid=%0b data=%h wa_valid=%0b expected 1 7777 0",
               xa_rd_valid, xa_data_out, wa_valid);
    end
  endtask

  task automatic test_wrap();
    int idx;
    int cyc;
    logic rdy;
    logic wr;
    logic rd;
    logic can;
    do_reset();
    idx = 0;
    cyc = 0;
    while (idx < 20 && cyc < 400) begin
      rdy = 1'($urandom_range(0, 1));
      can = (m_q.size() < DEPTH) || (rdy && m_q.size() > 0);
      wr  = can && ($urandom_range(0, 3) != 0);
      rd  = !wr && ($urandom_range(0, 2) == 0);
      step(wr, rd, wr ? DATA_W'(idx) : DATA_W'($urandom), rdy);
      if (wr) idx++;
      cyc++;
      checks++;
      if (level !== LW'(m_q.size()) || wa_valid !== (m_q.size() > 0) || wa_data !== m_head()
          || overflow !== m_ovf) begin
        errors++;
        $display("FAIL wrap_cycle%0d: level=%0d valid=%0b data=%h ovf=%0b expected %0d %0b %h %0b",
                 cyc, level, wa_valid, wa_data, overflow, m_q.size(), m_q.size() > 0, m_head(), m_ovf);
      end
      if (rd) begin
        checks++;
        if (xa_rd_valid !== m_rdv || xa_data_out !== m_rdata) begin
          errors++;
          $display("FAIL wrap_read%0d: rd_valid=%0b data=%h expected %0b %h",
                   cyc, xa_rd_valid, xa_data_out, m_rdv, m_rdata);
        end
      end
    end
    cyc = 0;
    while (wa_valid === 1'b1 && cyc < 20) begin
      step(1'b0, 1'b0, '0, 1'b1);
      cyc++;
    end
    checks++;
    if (idx != 20 || d_popped.size() != 20 || wa_valid !== 1'b0) begin
      errors++;
      $display("FAIL wrap_count: written=%0d popped=%0d valid=%0b expected 20 20 0",
               idx, d_popped.size(), wa_valid);
    end else begin
      for (int i = 0; i < 20; i++) begin
        checks++;
        if (d_popped[i] !== DATA_W'(i)) begin
          errors++;
          $display("FAIL wrap_order%0d: got %h expected %h", i, d_popped[i], DATA_W'(i));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_drain();
    test_overflow();
    test_full_pushpop();
    test_read_illegal();
    test_back_to_back();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sif_wa_responder.md
# sif_wa_responder

Synthesizable SIF responder that sits on the DUT side of the XA command interface. It decodes the `{rst_n, xa_wr_s, xa_rd_s}` operation set (WRITE, READ, IDLE, ILLEGAL, RESET) driven by the stimulus side and buffers written words in a FIFO. It forwards those words out on the WA side through a valid/ready handshake, and answers XA reads with the most recently written word. It produces the XA and WA traffic that the XA and WA monitors observe and the reference model predicts.

## Interface
- `DATA_W`, 16, width of XA and WA data words.
- `DEPTH`, 4, FIFO depth in words; power of two, >= 2.

- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `xa_wr_s`  in  1  XA write strobe.
- `xa_rd_s`  in  1  XA read strobe.
- `xa_data_in`  in  DATA_W  XA write data, sampled when a WRITE is decoded.
- `xa_data_out`  out  DATA_W  XA read data.
- `xa_rd_valid`  out  1  one-cycle pulse; `xa_data_out` is valid.
- `xa_illegal`  out  1  one-cycle pulse on an ILLEGAL command.
- `wa_valid`  out  1  WA word available.
- `wa_data`  out  DATA_W  WA word, FIFO head.
- `wa_ready`  in  1  WA sink accepts the word.
- `overflow`  out  1  sticky; a WRITE was dropped because the FIFO was full.
- `level`  out  $clog2(DEPTH)+1  current FIFO occupancy.

## Operation
- Command decode, per cycle, from `{xa_wr_s, xa_rd_s}`:
  - 10 = WRITE.
  - 01 = READ.
  - 00 = IDLE.
  - 11 = ILLEGAL.
- RESET (`rst_n`=0):
  - All outputs go to 0, the FIFO empties, `last_wr` (DATA_W register) goes to 0, and the FSM enters EMPTY.
- WRITE:
  - If the FIFO is not full, or a WA pop happens in the same cycle, push `xa_data_in` and set `last_wr` to `xa_data_in`.
  - Otherwise drop the word, leave `last_wr` unchanged, and set `overflow`.
- READ:
  - Next cycle: `xa_data_out` = `last_wr` and `xa_rd_valid` = 1 for one cycle.
  - `xa_data_out` holds its value until the next READ.
  - A READ does not affect the FIFO.
- ILLEGAL:
  - No push, no `last_wr` update, no read response.
  - `xa_illegal` = 1 for one cycle, the cycle after.
- IDLE: no XA effect; WA draining continues.
- WA pop: occurs when `wa_valid && wa_ready`. The FIFO head advances.
- `wa_data` always equals the head entry. It is 0 when empty.
- FSM, which controls `wa_valid`:
  - EMPTY (`wa_valid`=0): go to HOLD on a push.
  - HOLD (`wa_valid`=1, level >= 1):
    - Go to EMPTY on a pop with no push when level = 1.
    - Go to FULL when level reaches DEPTH.
  - FULL (`wa_valid`=1, level = DEPTH): go to HOLD on a pop with no push.
  - A push together with a pop leaves the level unchanged and keeps the state.
- Pointers are log2(DEPTH) bits and wrap naturally.
- Level arithmetic: `level` = `level` + push − pop, and stays in the range 0..DEPTH.
- `overflow` clears only on reset.

## Timing
- WRITE at edge N:
  - Word stored at N.
  - If the FIFO was empty, `wa_valid`=1 and `wa_data` = word during cycle N+1.
  - Write-to-WA latency is 1 cycle.
- WA handshake:
  - Pop is sampled at the edge where `wa_valid && wa_ready`.
  - The next head, or `wa_valid`=0, appears the following cycle.
  - `wa_valid` never depends combinationally on `wa_ready`.
  - `wa_data` is stable while `wa_valid`=1 and `wa_ready`=0.
- READ at edge N: `xa_rd_valid` is high in cycle N+1.
- WRITE at N followed by READ at N+1 returns the new word at N+2.
- Write while full with `wa_ready`=1 in the same cycle: the push is accepted, the level stays at DEPTH, and the FSM stays in FULL.
- Reset asserted mid-operation: takes effect immediately, without waiting for a clock edge. All FIFO content is lost and a pending `xa_rd_valid` or `xa_illegal` is cancelled.
- Reset release: the first edge with `rst_n`=1 decodes normally.

## Test plan
- Reset values:
  - Pulse `rst_n` low with the FIFO holding 3 words.
  - All outputs must go to 0 immediately, without waiting for a clock edge.
  - After release, `level`=0 and `wa_valid`=0.
- Write and drain:
  - WRITE 0x1234, 0xABCD, 0x0001 with `wa_ready`=0.
  - Expect `level`=3 and `wa_data`=0x1234.
  - Raise `wa_ready`: `wa_data` must be 0x1234, 0xABCD, 0x0001 on successive cycles, then `wa_valid`=0.
- Overflow:
  - With `wa_ready`=0, WRITE 5 words 0x0010..0x0014 (DEPTH=4).
  - Expect `level`=4 and `overflow`=1.
  - Drain yields 0x0010..0x0013 only.
  - A READ returns 0x0013.
- Full with simultaneous push/pop:
  - Fill to 4, then WRITE 0x00FF with `wa_ready`=1.
  - Expect `level`=4, FSM FULL, no overflow, and 0x00FF as the last word drained.
- READ and ILLEGAL:
  - WRITE 0xBEEF, then READ: `xa_rd_valid` pulses with 0xBEEF.
  - Then drive `xa_wr_s`=`xa_rd_s`=1 with `xa_data_in`=0x5555:
    - `xa_illegal` pulses for one cycle.
    - `level` is unchanged.
    - A following READ still returns 0xBEEF.
- Pointer wrap: stream 20 WRITEs 0x0000..0x0013 with random `wa_ready`. The WA output must reproduce 0x0000..0x0013 in order, with no loss.
